// File: rtl/noc_pkt_sf_pkg.sv
// Shared types and header-field helpers for the packet store-and-forward buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif

package noc_pkt_sf_pkg;

    // Input-side packet parser states
    typedef enum logic [1:0] {
        IN_HDR  = 2'd0,
        IN_BODY = 2'd1,
        IN_DROP = 2'd2
    } in_state_t;

    // Width of the header payload-length field
    localparam int LEN_W = 8;

    // Default flit width and header length-field position
    localparam int FLIT_W      = `NOC_DATA_WIDTH;
    localparam int HDR_LEN_MSB = 29;
    localparam int HDR_LEN_LSB = 22;

    // Payload length (body flits following the header) carried in a header flit
    function automatic logic [LEN_W-1:0] get_len(input logic [FLIT_W-1:0] flit);
        return flit[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/noc_pkt_sf_fifo.sv
// Generic show-ahead flop FIFO; head is the oldest entry, read combinationally.
// Latency: a pushed entry is visible at head the cycle after the push edge.
// Backpressure: caller must not push when full unless popping in the same cycle.
module noc_pkt_sf_fifo #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DATA_W-1:0]          head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       cnt;
    logic              do_push;
    logic              do_pop;

    assign full    = (cnt == DEPTH_CNT);
    assign empty   = (cnt == '0);
    assign count   = cnt;
    assign head    = mem[rd_ptr];
    // A pop frees the slot being written, so push-while-full is fine with a pop
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

`ifndef SYNTHESIS
    a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));
`endif

endmodule

// File: rtl/noc_pkt_sf_buffer.sv
// Packet store-and-forward buffer in front of the memory controller; drops oversize packets.
// Latency: output valid the cycle after a packet's last flit is accepted (min length+1 cycles).
// Backpressure: input ready = not full (always ready while dropping); output never stalls mid-packet.
// Optional build macro NOC_PKT_SF_STATS_EN adds saturating forwarded/dropped packet counters.
module noc_pkt_sf_buffer
    import noc_pkt_sf_pkg::*;
#(
    parameter int DATA_W  = `NOC_DATA_WIDTH,
    parameter int DEPTH   = 16,
    parameter int LEN_MSB = 29,
    parameter int LEN_LSB = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] flit_in_data,
    input  logic              flit_in_val,
    output logic              flit_in_rdy,
    output logic [DATA_W-1:0] mem_flit_in_data,
    output logic              mem_flit_in_val,
    input  logic              mem_flit_in_rdy,
    output logic              err_oversize
`ifdef NOC_PKT_SF_STATS_EN
    ,
    output logic [31:0]       stat_pkt_fwd,
    output logic [15:0]       stat_pkt_drop
`endif
);
    localparam int AW = $clog2(DEPTH);
    // Largest payload whose header plus body still fits in the storage
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DEPTH - 1);

    in_state_t         in_state;
    in_state_t         in_state_nxt;
    logic [LEN_W-1:0]  in_rem;
    logic [LEN_W-1:0]  in_rem_nxt;
    logic [LEN_W-1:0]  drop_rem;
    logic [LEN_W-1:0]  drop_rem_nxt;
    logic [LEN_W-1:0]  in_len;
    logic              in_fire;
    logic              fifo_push;
    logic              pkt_inc;
    logic              oversize_hdr;

    logic              fifo_full;
    logic              fifo_empty;
    logic [AW:0]       fifo_count;
    logic [DATA_W-1:0] fifo_head;

    logic [AW:0]       pkt_cnt;
    logic              active;
    logic              active_nxt;
    logic [LEN_W-1:0]  out_rem;
    logic [LEN_W-1:0]  out_rem_nxt;
    logic [LEN_W-1:0]  head_len;
    logic              out_fire;
    logic              pkt_dec;

    assign in_len   = flit_in_data[LEN_MSB:LEN_LSB];
    assign head_len = fifo_head[LEN_MSB:LEN_LSB];

    // Dropped flits are never stored, so a full FIFO must not stall a drop
    assign flit_in_rdy = !rst && ((in_state == IN_DROP) || !fifo_full);
    assign in_fire     = flit_in_val && flit_in_rdy;

    noc_pkt_sf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (flit_in_data),
        .pop       (out_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (fifo_head)
    );

    // Input parser state and remaining-flit counters
    always_ff @(posedge clk) begin
        if (rst) begin
            in_state <= IN_HDR;
            in_rem   <= '0;
            drop_rem <= '0;
        end else begin
            in_state <= in_state_nxt;
            in_rem   <= in_rem_nxt;
            drop_rem <= drop_rem_nxt;
        end
    end

    // Input parser transitions: header decides store / drop, body counts down
    always_comb begin
        in_state_nxt = in_state;
        in_rem_nxt   = in_rem;
        drop_rem_nxt = drop_rem;
        case (in_state)
            IN_HDR: begin
                if (in_fire) begin
                    if (in_len > MAX_LEN) begin
                        in_state_nxt = IN_DROP;
                        drop_rem_nxt = in_len;
                    end else if (in_len != '0) begin
                        in_state_nxt = IN_BODY;
                        in_rem_nxt   = in_len;
                    end
                end
            end
            IN_BODY: begin
                if (in_fire) begin
                    in_rem_nxt = in_rem - 1'b1;
                    if (in_rem == LEN_W'(1)) begin
                        in_state_nxt = IN_HDR;
                    end
                end
            end
            IN_DROP: begin
                if (in_fire) begin
                    drop_rem_nxt = drop_rem - 1'b1;
                    if (drop_rem == LEN_W'(1)) begin
                        in_state_nxt = IN_HDR;
                    end
                end
            end
            default: in_state_nxt = IN_HDR;
        endcase
    end

    // Input parser actions: store flit, mark packet complete, flag oversize
    always_comb begin
        fifo_push    = 1'b0;
        pkt_inc      = 1'b0;
        oversize_hdr = 1'b0;
        case (in_state)
            IN_HDR: begin
                if (in_fire) begin
                    if (in_len > MAX_LEN) begin
                        oversize_hdr = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                        pkt_inc   = (in_len == '0);
                    end
                end
            end
            IN_BODY: begin
                fifo_push = in_fire;
                pkt_inc   = in_fire && (in_rem == LEN_W'(1));
            end
            default: begin
                fifo_push    = 1'b0;
                pkt_inc      = 1'b0;
                oversize_hdr = 1'b0;
            end
        endcase
    end

    // Output offers data only for complete packets, so it never stalls mid-packet
    assign mem_flit_in_val  = !rst && (active || (pkt_cnt != '0));
    assign mem_flit_in_data = rst ? '0 : fifo_head;
    assign out_fire         = mem_flit_in_val && mem_flit_in_rdy;

    // Output tracking: header opens a packet, last body flit closes it
    always_comb begin
        active_nxt  = active;
        out_rem_nxt = out_rem;
        pkt_dec     = 1'b0;
        if (out_fire) begin
            if (!active) begin
                if (head_len == '0) begin
                    pkt_dec = 1'b1;
                end else begin
                    active_nxt  = 1'b1;
                    out_rem_nxt = head_len;
                end
            end else begin
                out_rem_nxt = out_rem - 1'b1;
                if (out_rem == LEN_W'(1)) begin
                    active_nxt = 1'b0;
                    pkt_dec    = 1'b1;
                end
            end
        end
    end

    // Output tracking registers
    always_ff @(posedge clk) begin
        if (rst) begin
            active  <= 1'b0;
            out_rem <= '0;
        end else begin
            active  <= active_nxt;
            out_rem <= out_rem_nxt;
        end
    end

    // Complete-but-undelivered packet count; simultaneous in/out cancel
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: pkt_cnt <= pkt_cnt;
            endcase
        end
    end

    // Sticky oversize-drop flag
    always_ff @(posedge clk) begin
        if (rst) begin
            err_oversize <= 1'b0;
        end else if (oversize_hdr) begin
            err_oversize <= 1'b1;
        end
    end

`ifdef NOC_PKT_SF_STATS_EN
    // Saturating forwarded / dropped packet counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_pkt_fwd  <= '0;
            stat_pkt_drop <= '0;
        end else begin
            if (pkt_dec && (stat_pkt_fwd != '1)) begin
                stat_pkt_fwd <= stat_pkt_fwd + 1'b1;
            end
            if (oversize_hdr && (stat_pkt_drop != '1)) begin
                stat_pkt_drop <= stat_pkt_drop + 1'b1;
            end
        end
    end
`endif

`ifndef SYNTHESIS
    a_pkt_no_underflow: assert property (@(posedge clk) disable iff (rst)
                                         !(pkt_dec && !pkt_inc && (pkt_cnt == '0)));
    // Every counted packet still holds at least one flit in storage
    a_pkt_has_flits:    assert property (@(posedge clk) disable iff (rst)
                                         (pkt_cnt <= fifo_count));
`endif

endmodule
